sr_cmd_sequencer: RTL and testbench

- Upstream drive stage for the SR flip-flop/gated latch. Converts set/clear requests into safely timed s/r/en pulses.
- Guarantees s and r are never high together.
- Waits a settle window after each pulse, then checks the q/qbar feedback from the latch.
- Reports done or fault per command and keeps a saturating fault count.

---
 rtl/sr_cmd_sequencer.sv | 142 ++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_sequencer.sv
// Command sequencer for an SR latch: turns set/clear requests into non-overlapping s/r/en pulses,
// waits for the latch to settle, then checks the q/qbar feedback and reports done or fault.
module sr_cmd_sequencer #(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int FCNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_req,
  input  logic              clr_req,
  output logic              req_ready,
  input  logic              q_fb,
  input  logic              qbar_fb,
  output logic              s,
  output logic              r,
  output logic              en,
  output logic              done,
  output logic              fault,
  output logic              conflict,
  output logic [FCNT_W-1:0] fault_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_CHECK  = 2'd3;

  localparam logic [7:0]        PULSE_LOAD  = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX    = {FCNT_W{1'b1}};
  localparam logic [FCNT_W-1:0] FCNT_ONE    = FCNT_W'(1'b1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              target_q, target_d;
  logic              ready_q, ready_d;
  logic              s_q, s_d, r_q, r_d, en_q, en_d;
  logic              done_q, done_d, fault_q, fault_d, conflict_q, conflict_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // Next-state, counter, target and pulse logic for the command FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    conflict_d = 1'b0;
    fcnt_d     = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ready_q && (set_req ^ clr_req)) begin
          target_d = set_req;
          cnt_d    = PULSE_LOAD;
          state_d  = ST_DRIVE;
        end else if (ready_q && set_req && clr_req) begin
          conflict_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if ((q_fb == target_q) && (qbar_fb == ~target_q)) begin
          done_d = 1'b1;
        end else begin
          fault_d = 1'b1;
          // Saturate rather than wrap so a long-running fault history stays visible.
          if (fcnt_q != FCNT_MAX) begin
            fcnt_d = fcnt_q + FCNT_ONE;
          end else begin
            fcnt_d = fcnt_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // Drive outputs derive from the next state so s and r can never overlap, even across transitions.
    ready_d = (state_d == ST_IDLE);
    en_d    = (state_d == ST_DRIVE);
    s_d     = en_d & target_d;
    r_d     = en_d & ~target_d;
  end

  // State and registered outputs; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      target_q   <= 1'b0;
      ready_q    <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      conflict_q <= 1'b0;
      fcnt_q     <= {FCNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      ready_q    <= ready_d;
      s_q        <= s_d;
      r_q        <= r_d;
      en_q       <= en_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      conflict_q <= conflict_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign req_ready   = ready_q;
  assign s           = s_q;
  assign r           = r_q;
  assign en          = en_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign conflict    = conflict_q;
  assign fault_count = fcnt_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Self-checking bench for sr_cmd_sequencer: directed reset/conflict/fault/saturation steps followed
// by randomized commands, all checked against a cycle-timeline reference model and a behavioural latch.
module tb_sr_cmd_sequencer;
  localparam int P  = 2;
  localparam int S  = 3;
  localparam int FW = 2;
  localparam int LAST = P + S + 2;
  localparam int FMAX = (1 << FW) - 1;

  logic clk, rst_n, set_req, clr_req;
  logic req_ready, q_fb, qbar_fb, s, r, en, done, fault, conflict;
  logic [FW-1:0] fault_count;

  int n_cmp = 0;
  int n_err = 0;
  int model_fc = 0;

  // Behavioural latch plus an override used to emulate stuck or broken feedback.
  logic latch_q = 1'b0;
  logic frc = 1'b0, frc_q = 1'b0, frc_qb = 1'b0;
  assign q_fb    = frc ? frc_q  : latch_q;
  assign qbar_fb = frc ? frc_qb : ~latch_q;

  sr_cmd_sequencer #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S), .FCNT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req), .req_ready(req_ready),
    .q_fb(q_fb), .qbar_fb(qbar_fb), .s(s), .r(r), .en(en), .done(done), .fault(fault),
    .conflict(conflict), .fault_count(fault_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (en === 1'b1 && s === 1'b1) latch_q = 1'b1;
    else if (en === 1'b1 && r === 1'b1) latch_q = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string ph, input logic e_s, input logic e_r, input logic e_en,
                         input logic e_rdy, input logic e_done, input logic e_fault,
                         input logic e_conf, input int e_fc);
    chk({ph, ".s"}, 32'(s), 32'(e_s));
    chk({ph, ".r"}, 32'(r), 32'(e_r));
    chk({ph, ".en"}, 32'(en), 32'(e_en));
    chk({ph, ".s_and_r"}, 32'(s & r), 32'd0);
    chk({ph, ".req_ready"}, 32'(req_ready), 32'(e_rdy));
    chk({ph, ".done"}, 32'(done), 32'(e_done));
    chk({ph, ".fault"}, 32'(fault), 32'(e_fault));
    chk({ph, ".conflict"}, 32'(conflict), 32'(e_conf));
    chk({ph, ".fault_count"}, 32'(fault_count), e_fc);
  endtask

  // One full command: wait for ready, present request, then check every cycle up to done/fault.
  task automatic run_cmd(input string ph, input bit is_set, input bit f_en, input logic f_q,
                         input logic f_qb, input int hold);
    bit ok;
    int old_fc;
    bit drv;
    for (int k = 0; k < 20 && req_ready !== 1'b1; k++) @(negedge clk);
    chk({ph, ".ready_wait"}, 32'(req_ready), 32'd1);
    frc = f_en; frc_q = f_q; frc_qb = f_qb;
    ok = f_en ? (f_q === is_set && f_qb === !is_set) : 1'b1;
    old_fc = model_fc;
    if (!ok) model_fc = (model_fc < FMAX) ? model_fc + 1 : FMAX;
    set_req = is_set; clr_req = !is_set;
    @(posedge clk);
    for (int i = 1; i <= LAST; i++) begin
      @(negedge clk);
      if (i >= hold) begin set_req = 1'b0; clr_req = 1'b0; end
      drv = (i <= P);
      chk_all($sformatf("%s.c%0d", ph, i), drv & is_set, drv & !is_set, drv, i == LAST,
              (i == LAST) && ok, (i == LAST) && !ok, 1'b0, (i == LAST) ? model_fc : old_fc);
    end
  endtask

  initial begin
    rst_n = 1'b0; set_req = 1'b0; clr_req = 1'b0;
    #1;
    chk_all("reset_t0", 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_all("reset_held", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1 chk("release.ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk_all("release.first_edge", 0, 0, 0, 1, 0, 0, 0, 0);

    run_cmd("set1", 1'b1, 1'b0, 1'b0, 1'b0, 1);
    chk("set1.q_fb", 32'(q_fb), 32'd1);
    run_cmd("clr_b2b", 1'b0, 1'b0, 1'b0, 1'b0, 2);
    chk("clr_b2b.q_fb", 32'(q_fb), 32'd0);

    // Both requests high while idle: conflict each cycle, nothing accepted.
    @(negedge clk);
    set_req = 1'b1; clr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all($sformatf("conflict.c%0d", i), 0, 0, 0, 1, 0, 0, 1, model_fc);
    end
    set_req = 1'b0; clr_req = 1'b0;
    @(negedge clk);
    chk_all("conflict.clear", 0, 0, 0, 1, 0, 0, 0, model_fc);
    run_cmd("set_after_conf", 1'b1, 1'b0, 1'b0, 1'b0, 1);
    run_cmd("set_redundant", 1'b1, 1'b0, 1'b0, 1'b0, 3);

    run_cmd("stuck_set", 1'b1, 1'b1, 1'b0, 1'b1, 1);
    run_cmd("equal_fb_clr", 1'b0, 1'b1, 1'b1, 1'b1, 1);
    run_cmd("sat3", 1'b1, 1'b1, 1'b0, 1'b1, 1);
    run_cmd("sat4", 1'b0, 1'b1, 1'b1, 1'b0, 1);
    run_cmd("sat5", 1'b1, 1'b1, 1'b0, 1'b0, 1);
    chk("sat.final_count", 32'(fault_count), 32'(FMAX));

    // Reset during the second DRIVE cycle aborts the command.
    frc = 1'b0;
    @(negedge clk);
    set_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_req = 1'b0;
    chk("middrive.driving", 32'(en), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_fc = 0;
    #1 chk_all("middrive.in_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all($sformatf("middrive.after%0d", i), 0, 0, 0, 1, 0, 0, 0, 0);
    end
    run_cmd("middrive.next_set", 1'b1, 1'b0, 1'b0, 1'b0, 1);

    // Randomized commands with idle gaps, conflicts and occasional broken feedback.
    for (int n = 0; n < 60; n++) begin
      int gap;
      bit both;
      bit bad;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        both = ($urandom_range(0, 3) == 0);
        set_req = both; clr_req = both;
        @(negedge clk);
        chk_all($sformatf("rnd%0d.gap%0d", n, g), 0, 0, 0, 1, 0, 0, both, model_fc);
        set_req = 1'b0; clr_req = 1'b0;
      end
      bad = ($urandom_range(0, 3) == 0);
      run_cmd($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), bad,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      frc = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
